// File: rtl/test_sequence_checker_pkg.sv
// Shared definitions for the test sequence checker: FSM state encoding and default widths.
package test_sequence_checker_pkg;

    localparam int unsigned DefaultTestIAddrWidth = 5;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/checker_lane_cmp.sv
// One response channel's masked compare: flags any differing bit that the mask selects.
module checker_lane_cmp #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] resp,
    input  logic [DATA_WIDTH-1:0] exp_val,
    input  logic [DATA_WIDTH-1:0] mask,
    output logic                  mismatch
);

    assign mismatch = |((resp ^ exp_val) & mask);

endmodule

// File: rtl/test_sequence_checker.sv
// Self-checking test sequencer: issues test indices to a DUT, compares masked responses per
// channel and accumulates pass/fail, failure count, first failing test and timeout status.
module test_sequence_checker
    import test_sequence_checker_pkg::*;
#(
    parameter int unsigned TEST_I_ADDR_WIDTH = DefaultTestIAddrWidth,
    parameter int unsigned NUM_TESTS         = 16,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned NUM_CH            = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 64,
    parameter bit          STOP_ON_FAIL      = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [TEST_I_ADDR_WIDTH-1:0]   test,
    output logic                           test_valid,
    input  logic                           test_ready,
    input  logic                           resp_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   resp_data,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   exp_data,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   exp_mask,
    output logic                           busy,
    output logic                           done,
    output logic                           result,
    output logic [TEST_I_ADDR_WIDTH:0]     fail_count,
    output logic [TEST_I_ADDR_WIDTH-1:0]   first_fail,
    output logic [NUM_CH-1:0]              fail_ch,
    output logic                           timeout
);

    localparam int unsigned AW = TEST_I_ADDR_WIDTH;
    localparam int unsigned FW = TEST_I_ADDR_WIDTH + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BW = NUM_CH * DATA_WIDTH;

    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] LastTest  = AW'(NUM_TESTS - 1);

    if (NUM_TESTS > (1 << TEST_I_ADDR_WIDTH)) begin : gen_bad_num_tests
        $error("NUM_TESTS does not fit in TEST_I_ADDR_WIDTH bits");
    end
    if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e          state_q, state_d;
    logic [AW-1:0]   test_q, test_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   fail_count_q, fail_count_d;
    logic [AW-1:0]   first_fail_q, first_fail_d;
    logic [NUM_CH-1:0] fail_ch_q, fail_ch_d;
    logic            timeout_q, timeout_d;
    logic            tmo_cur_q, tmo_cur_d;
    logic [BW-1:0]   resp_q, resp_d;
    logic [BW-1:0]   exp_q, exp_d;
    logic [BW-1:0]   mask_q, mask_d;
    logic            test_valid_q, test_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            result_q, result_d;

    logic [NUM_CH-1:0] mismatch;
    logic              test_fail;
    logic [NUM_CH-1:0] fail_flags;

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_lane
        checker_lane_cmp #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cmp (
            .resp     (resp_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .exp_val  (exp_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .mask     (mask_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .mismatch (mismatch[c])
        );
    end

    // A timed-out test compares stale data, so its flags are forced to all channels.
    assign test_fail  = tmo_cur_q | (|mismatch);
    assign fail_flags = tmo_cur_q ? {NUM_CH{1'b1}} : mismatch;

    always_comb begin
        state_d      = state_q;
        test_d       = test_q;
        timer_d      = timer_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        fail_ch_d    = fail_ch_q;
        timeout_d    = timeout_q;
        tmo_cur_d    = tmo_cur_q;
        resp_d       = resp_q;
        exp_d        = exp_q;
        mask_d       = mask_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StIssue;
                    test_d       = '0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    fail_ch_d    = '0;
                    timeout_d    = 1'b0;
                end
            end
            StIssue: begin
                if (test_ready) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                if (resp_valid) begin
                    state_d   = StCheck;
                    tmo_cur_d = 1'b0;
                    resp_d    = resp_data;
                    exp_d     = exp_data;
                    mask_d    = exp_mask;
                end else if (timer_q == TimerLast) begin
                    state_d   = StCheck;
                    tmo_cur_d = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StCheck: begin
                if (test_fail) begin
                    if (fail_count_q == '0) begin
                        first_fail_d = test_q;
                        fail_ch_d    = fail_flags;
                    end
                    if (fail_count_q != {FW{1'b1}}) begin
                        fail_count_d = fail_count_q + FW'(1);
                    end
                end
                if ((test_q == LastTest) || (STOP_ON_FAIL && test_fail)) begin
                    state_d = StDone;
                end else begin
                    test_d  = test_q + AW'(1);
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase

        // Status outputs are registered from the next state so they never depend on inputs.
        test_valid_d = (state_d == StIssue);
        busy_d       = (state_d == StIssue) || (state_d == StWait) || (state_d == StCheck);
        done_d       = (state_d == StDone);
        result_d     = done_d && (fail_count_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            test_q       <= '0;
            timer_q      <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            fail_ch_q    <= '0;
            timeout_q    <= 1'b0;
            tmo_cur_q    <= 1'b0;
            resp_q       <= '0;
            exp_q        <= '0;
            mask_q       <= '0;
            test_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            test_q       <= test_d;
            timer_q      <= timer_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            fail_ch_q    <= fail_ch_d;
            timeout_q    <= timeout_d;
            tmo_cur_q    <= tmo_cur_d;
            resp_q       <= resp_d;
            exp_q        <= exp_d;
            mask_q       <= mask_d;
            test_valid_q <= test_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

    assign test       = test_q;
    assign test_valid = test_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;
    assign fail_ch    = fail_ch_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_test_sequence_checker.sv
// Bench for test_sequence_checker: a per-test timeline model predicts every cycle's outputs for
// a run-all instance and a stop-on-fail instance driven by the same directed stimulus.
module tb_test_sequence_checker;

    localparam int NT = 16;
    localparam int TO = 64;

    typedef struct packed {
        logic [4:0] test;
        logic       tv;
        logic       busy;
        logic       done;
        logic       result;
        logic [5:0] fc;
        logic [4:0] ff;
        logic [1:0] fch;
        logic       tmo;
    } obs_t;

    typedef struct {
        obs_t o;
        logic rdy;
        logic rv;
        int   ph;   // 0 issue, 1 wait, 2 check, 3 done
    } cyc_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        test_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [15:0] exp_data;
    logic [15:0] exp_mask;

    logic [4:0] test0, test1, ff0, ff1;
    logic       tv0, tv1, busy0, busy1, done0, done1, result0, result1, tmo0, tmo1;
    logic [5:0] fc0, fc1;
    logic [1:0] fch0, fch1;
    obs_t       o0, o1;

    assign o0 = {test0, tv0, busy0, done0, result0, fc0, ff0, fch0, tmo0};
    assign o1 = {test1, tv1, busy1, done1, result1, fc1, ff1, fch1, tmo1};

    test_sequence_checker #(
        .TEST_I_ADDR_WIDTH (5),
        .NUM_TESTS         (NT),
        .DATA_WIDTH        (8),
        .NUM_CH            (2),
        .TIMEOUT_CYCLES    (TO),
        .STOP_ON_FAIL      (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .test       (test0),
        .test_valid (tv0),
        .test_ready (test_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .exp_data   (exp_data),
        .exp_mask   (exp_mask),
        .busy       (busy0),
        .done       (done0),
        .result     (result0),
        .fail_count (fc0),
        .first_fail (ff0),
        .fail_ch    (fch0),
        .timeout    (tmo0)
    );

    test_sequence_checker #(
        .TEST_I_ADDR_WIDTH (5),
        .NUM_TESTS         (NT),
        .DATA_WIDTH        (8),
        .NUM_CH            (2),
        .TIMEOUT_CYCLES    (TO),
        .STOP_ON_FAIL      (1'b1)
    ) dut_sof (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .test       (test1),
        .test_valid (tv1),
        .test_ready (test_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .exp_data   (exp_data),
        .exp_mask   (exp_mask),
        .busy       (busy1),
        .done       (done1),
        .result     (result1),
        .fail_count (fc1),
        .first_fail (ff1),
        .fail_ch    (fch1),
        .timeout    (tmo1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          passed = 0;
    int          total  = 0;
    int          busy_n0, busy_n1;
    int          rdy_dly[NT];
    int          rsp_dly[NT];   // >= TO means the response never comes
    logic [15:0] err[NT];
    logic [15:0] mask;
    cyc_t        sch0[$];
    cyc_t        sch1[$];

    function automatic logic [15:0] rom(input logic [4:0] t);
        logic [7:0] tt;
        tt = {3'b000, t};
        return {tt * 8'd7 + 8'd3, tt ^ 8'hA5};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t req);
        total++;
        if (act !== req) begin
            $display("FAIL %s: got test=%0d tv=%b busy=%b done=%b res=%b fc=%0d ff=%0d fch=%b tmo=%b, want test=%0d tv=%b busy=%b done=%b res=%b fc=%0d ff=%0d fch=%b tmo=%b",
                     name, act.test, act.tv, act.busy, act.done, act.result, act.fc, act.ff,
                     act.fch, act.tmo, req.test, req.tv, req.busy, req.done, req.result, req.fc,
                     req.ff, req.fch, req.tmo);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_lit(input string name, input int act, input int req);
        total++;
        if (act != req) $display("FAIL %s: got %0d want %0d", name, act, req);
        else passed++;
    endtask

    task automatic clear_cfg();
        for (int t = 0; t < NT; t++) begin
            rdy_dly[t] = 0;
            rsp_dly[t] = 0;
            err[t]     = 16'h0000;
        end
        mask = 16'hFFFF;
    endtask

    task automatic push(input int which, input cyc_t e);
        if (which == 0) sch0.push_back(e);
        else            sch1.push_back(e);
    endtask

    // Lays out the expected run test by test: ISSUE until ready, WAIT until response or
    // expiry, one CHECK cycle, then the result totals the spec's rules give.
    task automatic build(input int which, input bit stop);
        obs_t       o;
        cyc_t       e;
        logic [5:0] fc   = '0;
        logic [4:0] ff   = '0;
        logic [1:0] fch  = '0;
        logic       tmo  = 1'b0;
        logic [1:0] mm;
        int         last = 0;
        bit         timed;
        int         w;
        for (int t = 0; t < NT; t++) begin
            last  = t;
            timed = (rsp_dly[t] >= TO);
            w     = timed ? TO : rsp_dly[t] + 1;
            o      = '0;
            o.test = t[4:0];
            o.busy = 1'b1;
            o.fc   = fc;
            o.ff   = ff;
            o.fch  = fch;
            o.tmo  = tmo;
            for (int i = 0; i <= rdy_dly[t]; i++) begin
                e.o = o; e.o.tv = 1'b1; e.rdy = (i == rdy_dly[t]); e.rv = 1'b0; e.ph = 0;
                push(which, e);
            end
            for (int i = 0; i < w; i++) begin
                e.o = o; e.rdy = 1'b0; e.rv = (i == rsp_dly[t]); e.ph = 1;
                push(which, e);
            end
            e.o = o; e.o.tmo = tmo | timed; e.rdy = 1'b0; e.rv = 1'b0; e.ph = 2;
            push(which, e);
            for (int c = 0; c < 2; c++) mm[c] = ((err[t][c*8 +: 8] & mask[c*8 +: 8]) != 8'h00);
            if (timed) mm = 2'b11;
            tmo = tmo | timed;
            if (timed || mm != 2'b00) begin
                if (fc == 6'd0) begin
                    ff  = t[4:0];
                    fch = mm;
                end
                if (fc != 6'h3F) fc = fc + 6'd1;
                if (stop) break;
            end
        end
        o        = '0;
        o.test   = last[4:0];
        o.done   = 1'b1;
        o.result = (fc == 6'd0);
        o.fc     = fc;
        o.ff     = ff;
        o.fch    = fch;
        o.tmo    = tmo;
        // Stray handshakes in DONE must be ignored.
        for (int i = 0; i < 4; i++) begin
            e.o = o; e.rdy = 1'b1; e.rv = 1'b1; e.ph = 3;
            push(which, e);
        end
    endtask

    task automatic run(input string name, input int pulse_k, input bit abort7);
        cyc_t e0, e1;
        sch0.delete();
        sch1.delete();
        build(0, 1'b0);
        build(1, 1'b1);
        busy_n0 = 0;
        busy_n1 = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < sch0.size(); k++) begin
            e0 = sch0[k];
            e1 = (k < sch1.size()) ? sch1[k] : sch1[sch1.size()-1];
            check({name, "_run"}, o0, e0.o);
            check({name, "_sof"}, o1, e1.o);
            busy_n0 += int'(busy0);
            busy_n1 += int'(busy1);
            if (abort7 && e0.ph == 1 && e0.o.test == 5'd7) begin
                #2 reset = 1'b0;
                #1;
                check({name, "_rst_run"}, o0, '0);
                check({name, "_rst_sof"}, o1, '0);
                @(negedge clk);
                reset      = 1'b1;
                test_ready = 1'b0;
                resp_valid = 1'b0;
                return;
            end
            start      = (k == pulse_k);
            test_ready = e0.rdy;
            resp_valid = e0.rv;
            exp_data   = rom(e0.o.test);
            resp_data  = rom(e0.o.test) ^ err[e0.o.test[3:0]];
            @(negedge clk);
        end
        start      = 1'b0;
        test_ready = 1'b0;
        resp_valid = 1'b0;
    endtask

    assign exp_mask = mask;

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        test_ready = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        exp_data   = '0;
        clear_cfg();
        repeat (3) @(negedge clk);
        check("reset_run", o0, '0);
        check("reset_sof", o1, '0);
        reset = 1'b1;

        // All tests match
        clear_cfg();
        run("all_pass", -1, 1'b0);
        chk_lit("all_pass_busy", busy_n0, 48);
        chk_lit("all_pass_result", int'(result0), 1);
        chk_lit("all_pass_fc", int'(fc0), 0);
        chk_lit("all_pass_tmo", int'(tmo0), 0);

        // Channel 1 of test 5 mismatches
        clear_cfg();
        err[5] = 16'h0100;
        run("ch1_t5", -1, 1'b0);
        chk_lit("ch1_t5_busy", busy_n0, 48);
        chk_lit("ch1_t5_result", int'(result0), 0);
        chk_lit("ch1_t5_fc", int'(fc0), 1);
        chk_lit("ch1_t5_ff", int'(ff0), 5);
        chk_lit("ch1_t5_fch", int'(fch0), 2);
        chk_lit("ch1_t5_sof_test", int'(test1), 5);
        chk_lit("ch1_t5_sof_fc", int'(fc1), 1);
        chk_lit("ch1_t5_sof_busy", busy_n1, 18);

        // Mismatches only in masked-off bits, plus a slow test_ready
        clear_cfg();
        mask    = 16'hFF0F;
        err[2]  = 16'h00F0;
        err[11] = 16'h00F0;
        rdy_dly[4] = 2;
        run("masked", -1, 1'b0);
        chk_lit("masked_busy", busy_n0, 50);
        chk_lit("masked_result", int'(result0), 1);

        // Test 3 never responds; test 8 responds on the last WAIT cycle
        clear_cfg();
        rsp_dly[3] = 1000;
        rsp_dly[8] = TO - 1;
        run("tmo", -1, 1'b0);
        chk_lit("tmo_busy", busy_n0, 174);
        chk_lit("tmo_flag", int'(tmo0), 1);
        chk_lit("tmo_ff", int'(ff0), 3);
        chk_lit("tmo_fch", int'(fch0), 3);
        chk_lit("tmo_fc", int'(fc0), 1);
        chk_lit("tmo_sof_busy", busy_n1, 75);

        clear_cfg();
        rsp_dly[8] = TO - 1;
        run("late_ok", -1, 1'b0);
        chk_lit("late_ok_busy", busy_n0, 111);
        chk_lit("late_ok_tmo", int'(tmo0), 0);
        chk_lit("late_ok_result", int'(result0), 1);

        // Every test fails on channel 0
        clear_cfg();
        for (int t = 0; t < NT; t++) err[t] = 16'h0001;
        run("all_fail", -1, 1'b0);
        chk_lit("all_fail_fc", int'(fc0), 16);
        chk_lit("all_fail_ff", int'(ff0), 0);
        chk_lit("all_fail_fch", int'(fch0), 1);
        chk_lit("all_fail_sof_busy", busy_n1, 3);

        // Reset during WAIT of test 7, then a fresh run with start pulsed while busy
        clear_cfg();
        run("abort", -1, 1'b1);
        clear_cfg();
        run("rerun", 10, 1'b0);
        chk_lit("rerun_busy", busy_n0, 48);
        chk_lit("rerun_result", int'(result0), 1);
        chk_lit("rerun_test", int'(test0), 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
